shift_reg_universal: RTL and testbench
======================================

// Module: shift_reg_universal
//
// PURPOSE
//   Parametrised successor to the single-bit gate-level D flip-flop.
//   A WIDTH-bit register bank with true and complement outputs.
//   Four modes: hold, shift right, shift left, parallel load.
//   Serial ports allow cascading of several instances.
//   A shift counter flags each full-width pass, so serial frames
//   can be framed without external counting.
//
// PARAMETERS
//   WIDTH      4   register width in bits; legal values >= 2
//   RESET_VAL  0   WIDTH-bit value loaded into Q on reset
//
// PORTS
//   Clk        in   1             rising-edge clock
//   Rst        in   1             synchronous, active-high reset
//   En         in   1             1 = execute Mode this edge; 0 = hold
//   Mode       in   2             00 hold, 01 shift right, 10 shift left, 11 load
//   D          in   WIDTH         parallel load data
//   SerInMsb   in   1             serial input, enters at bit WIDTH-1 on shift right
//   SerInLsb   in   1             serial input, enters at bit 0 on shift left
//   Q          out  WIDTH         register contents
//   Qb         out  WIDTH         ~Q
//   SerOutLsb  out  1             Q[0]; the bit lost on the next shift right
//   SerOutMsb  out  1             Q[WIDTH-1]; the bit lost on the next shift left
//   ShiftCnt   out  $clog2(WIDTH) shifts executed since the last load, reset or wrap
//   Wrap       out  1             one-cycle pulse after the WIDTH-th shift
//
// BEHAVIOUR
//   - All state updates on the rising edge of Clk. Q, ShiftCnt and Wrap are registered.
//   - Qb, SerOutLsb and SerOutMsb are combinational from Q, with zero latency.
//   - Priority at each edge: Rst > (En==0) > Mode.
//   - Reset: Q=RESET_VAL, Qb=~RESET_VAL, ShiftCnt=0, Wrap=0.
//     Reset applies regardless of En or Mode and aborts any shift sequence.
//   - En==0, or Mode==00: Q and ShiftCnt hold; Wrap<=0.
//   - Mode 01 (shift right): Q <= {SerInMsb, Q[WIDTH-1:1]}.
//   - Mode 10 (shift left):  Q <= {Q[WIDTH-2:0], SerInLsb}.
//   - Mode 11 (load): Q <= D; ShiftCnt <= 0; Wrap <= 0.
//   - ShiftCnt counts executed shifts in either direction.
//     - Shift with ShiftCnt < WIDTH-1: ShiftCnt+1, Wrap<=0.
//     - Shift with ShiftCnt == WIDTH-1: ShiftCnt<=0, Wrap<=1.
//       Wrap is high for exactly the next cycle.
//     - Consecutive wrapping is impossible: it needs WIDTH >= 2 shifts.
//     - For non-power-of-two WIDTH, the counter wraps at WIDTH-1, never at 2^n-1.
//   - Direction changes mid-sequence do not clear ShiftCnt.
//   - Serial inputs are sampled only on the executing edge; they are don't-care otherwise.
//
// CONFIGURATION
//   SHIFT_REG_ROTATE_EN
//   - Defined: adds input port Rot (1 bit), placed after Mode.
//     - Rot==1 with Mode 01 rotates right: Q <= {Q[0], Q[WIDTH-1:1]}.
//     - Rot==1 with Mode 10 rotates left:  Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
//     - In both cases the serial inputs are ignored.
//     - Rot has no effect on hold or load.
//     - ShiftCnt and Wrap behave exactly as for a shift.
//   - Undefined: Rot port absent; shifts always take the serial inputs.
//
// TESTING (WIDTH=4, RESET_VAL=4'b0000 unless stated)
//   1. Rst=1 for one edge, with Mode=11 and D=1111
//      -> Q=0000, Qb=1111, ShiftCnt=0, Wrap=0 (reset beats load).
//   2. En=1, Mode=11, D=1010 -> Q=1010.
//      Then En=0, Mode=11, D=0101 -> Q stays 1010.
//   3. From Q=1010: four edges Mode=01, SerInMsb=1
//      -> Q: 1101, 1110, 1111, 1111.
//      -> SerOutLsb before each edge: 0, 1, 0, 1.
//      -> ShiftCnt: 1, 2, 3, 0.
//      -> Wrap=1 only after the 4th edge, 0 the cycle after with Mode=00.
//   4. From Q=1111: Mode=10, SerInLsb=0 -> Q=1110, SerOutMsb=1 before the edge.
//      Then Mode=11, D=0011 -> Q=0011, ShiftCnt=0.
//   5. Reset mid-sequence: ShiftCnt=2, Mode=01, Rst=1
//      -> Q=0000, ShiftCnt=0, Wrap=0 next cycle.
//      Repeat with RESET_VAL=4'b1001 -> Q=1001, Qb=0110.
//   6. With SHIFT_REG_ROTATE_EN and Rot=1, from Q=1000:
//      -> Mode=01 gives Q=0100.
//      -> Mode=10 twice gives 1000, then 0001.
//      -> Serial inputs are held at 1 throughout and must not appear in Q.

Source files
------------

// File: rtl/shift_reg_universal_if.sv
// Signal bundle for shift_reg_universal: control, data and serial ports plus register outputs.
// The Rot input exists only when SHIFT_REG_ROTATE_EN is defined.
interface shift_reg_universal_if #(
  parameter int WIDTH = 4
);
  logic                     En;
  logic [1:0]               Mode;
`ifdef SHIFT_REG_ROTATE_EN
  logic                     Rot;
`endif
  logic [WIDTH-1:0]         D;
  logic                     SerInMsb;
  logic                     SerInLsb;
  logic [WIDTH-1:0]         Q;
  logic [WIDTH-1:0]         Qb;
  logic                     SerOutLsb;
  logic                     SerOutMsb;
  logic [$clog2(WIDTH)-1:0] ShiftCnt;
  logic                     Wrap;

  modport master (
`ifdef SHIFT_REG_ROTATE_EN
    output Rot,
`endif
    output En, Mode, D, SerInMsb, SerInLsb,
    input  Q, Qb, SerOutLsb, SerOutMsb, ShiftCnt, Wrap
  );

  modport slave (
`ifdef SHIFT_REG_ROTATE_EN
    input  Rot,
`endif
    input  En, Mode, D, SerInMsb, SerInLsb,
    output Q, Qb, SerOutLsb, SerOutMsb, ShiftCnt, Wrap
  );
endinterface

// File: rtl/shift_reg_universal.sv
// Universal WIDTH-bit shift register: hold / shift right / shift left / load, with a
// full-pass shift counter and Wrap pulse. Define SHIFT_REG_ROTATE_EN to add rotate via Rot.
module shift_reg_universal #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                   Clk,
  input  logic                   Rst,
  shift_reg_universal_if.slave   bus
);
  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             shift;
  logic             rot;
  mode_e            mode;

  assign mode = mode_e'(bus.Mode);

`ifdef SHIFT_REG_ROTATE_EN
  assign rot = bus.Rot;
`else
  assign rot = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    q_d    = q_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    shift  = 1'b0;
    if (bus.En) begin
      unique case (mode)
        MODE_HOLD: ;
        MODE_SHR: begin
          q_d   = {(rot ? q_q[0] : bus.SerInMsb), q_q[WIDTH-1:1]};
          shift = 1'b1;
        end
        MODE_SHL: begin
          q_d   = {q_q[WIDTH-2:0], (rot ? q_q[WIDTH-1] : bus.SerInLsb)};
          shift = 1'b1;
        end
        MODE_LOAD: begin
          q_d   = bus.D;
          cnt_d = '0;
        end
      endcase
    end
    // Counter wraps at WIDTH-1 explicitly so non-power-of-two widths frame correctly.
    if (shift) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (Rst) begin
      q_q    <= RESET_VAL;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.Q         = q_q;
  assign bus.Qb        = ~q_q;
  assign bus.SerOutLsb = q_q[0];
  assign bus.SerOutMsb = q_q[WIDTH-1];
  assign bus.ShiftCnt  = cnt_q;
  assign bus.Wrap      = wrap_q;
endmodule

// File: tb/tb_shift_reg_universal.sv
// Randomised + directed bench for shift_reg_universal: three instances (W4/R0, W4/R1001,
// W5/R10110) driven in lockstep and compared against an arithmetic reference model.
module tb_shift_reg_universal;
  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

`ifdef SHIFT_REG_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  shift_reg_universal_if #(.WIDTH(4)) if0 ();
  shift_reg_universal_if #(.WIDTH(4)) if1 ();
  shift_reg_universal_if #(.WIDTH(5)) if2 ();

  shift_reg_universal #(.WIDTH(4), .RESET_VAL(4'b0000))  dut0 (.Clk(Clk), .Rst(Rst), .bus(if0));
  shift_reg_universal #(.WIDTH(4), .RESET_VAL(4'b1001))  dut1 (.Clk(Clk), .Rst(Rst), .bus(if1));
  shift_reg_universal #(.WIDTH(5), .RESET_VAL(5'b10110)) dut2 (.Clk(Clk), .Rst(Rst), .bus(if2));

  int n_tests = 0;
  int n_fail  = 0;

  int w_of[3]  = '{4, 4, 5};
  int rv_of[3] = '{0, 9, 22};
  int mq[3];
  int mc[3];
  int mw[3];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: register as an integer, shifts as arithmetic, counter modulo width.
  task automatic model_edge(bit rst, bit en, bit [1:0] mode, bit [7:0] d,
                            bit smsb, bit slsb, bit rot);
    for (int i = 0; i < 3; i++) begin
      int w, mask, inb;
      w    = w_of[i];
      mask = (1 << w) - 1;
      if (rst) begin
        mq[i] = rv_of[i]; mc[i] = 0; mw[i] = 0;
      end else if (!en || mode == 2'd0) begin
        mw[i] = 0;
      end else if (mode == 2'd3) begin
        mq[i] = int'(d) & mask; mc[i] = 0; mw[i] = 0;
      end else begin
        if (mode == 2'd1) begin
          inb   = (ROT_EN && rot) ? (mq[i] % 2) : int'(smsb);
          mq[i] = (mq[i] / 2) + inb * (1 << (w - 1));
        end else begin
          inb   = (ROT_EN && rot) ? (mq[i] / (1 << (w - 1))) : int'(slsb);
          mq[i] = (mq[i] * 2 + inb) & mask;
        end
        mc[i] = mc[i] + 1;
        if (mc[i] == w) begin mc[i] = 0; mw[i] = 1; end
        else mw[i] = 0;
      end
    end
  endtask

  task automatic cmp_inst(string ph, int i, logic [7:0] q, logic [7:0] qb, logic sol,
                          logic som, logic [7:0] cnt, logic wrap, bit post);
    int mask;
    mask = (1 << w_of[i]) - 1;
    check($sformatf("%s%0d_q", ph, i), 32'(q), 32'(mq[i]));
    check($sformatf("%s%0d_qb", ph, i), 32'(qb), 32'((~mq[i]) & mask));
    check($sformatf("%s%0d_serlsb", ph, i), 32'(sol), 32'(mq[i] % 2));
    check($sformatf("%s%0d_sermsb", ph, i), 32'(som), 32'(mq[i] / (1 << (w_of[i] - 1))));
    if (post) begin
      check($sformatf("%s%0d_cnt", ph, i), 32'(cnt), 32'(mc[i]));
      check($sformatf("%s%0d_wrap", ph, i), 32'(wrap), 32'(mw[i]));
    end
  endtask

  task automatic cmp_all(string ph, bit post);
    cmp_inst(ph, 0, 8'(if0.Q), 8'(if0.Qb), if0.SerOutLsb, if0.SerOutMsb, 8'(if0.ShiftCnt), if0.Wrap, post);
    cmp_inst(ph, 1, 8'(if1.Q), 8'(if1.Qb), if1.SerOutLsb, if1.SerOutMsb, 8'(if1.ShiftCnt), if1.Wrap, post);
    cmp_inst(ph, 2, 8'(if2.Q), 8'(if2.Qb), if2.SerOutLsb, if2.SerOutMsb, 8'(if2.ShiftCnt), if2.Wrap, post);
  endtask

  task automatic drive(bit rst, bit en, bit [1:0] mode, bit [7:0] d, bit smsb, bit slsb, bit rot);
    Rst = rst;
    if0.En = en; if0.Mode = mode; if0.D = d[3:0]; if0.SerInMsb = smsb; if0.SerInLsb = slsb;
    if1.En = en; if1.Mode = mode; if1.D = d[3:0]; if1.SerInMsb = smsb; if1.SerInLsb = slsb;
    if2.En = en; if2.Mode = mode; if2.D = d[4:0]; if2.SerInMsb = smsb; if2.SerInLsb = slsb;
`ifdef SHIFT_REG_ROTATE_EN
    if0.Rot = rot; if1.Rot = rot; if2.Rot = rot;
`endif
  endtask

  // One clock: drive, check combinational outputs before the edge, check all after it.
  task automatic step(bit rst, bit en, bit [1:0] mode, bit [7:0] d,
                      bit smsb, bit slsb, bit rot);
    bit [7:0] dm;
    dm = d;
    drive(rst, en, mode, dm, smsb, slsb, rot);
    #1;
    cmp_all("pre", 1'b0);
    model_edge(rst, en, mode, dm, smsb, slsb, rot);
    @(posedge Clk);
    #1;
    cmp_all("post", 1'b1);
  endtask

  initial begin
    bit [3:0] exp_q[4]   = '{4'b1101, 4'b1110, 4'b1111, 4'b1111};
    bit       exp_sol[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int       exp_cnt[4] = '{1, 2, 3, 0};
    bit       exp_wr[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};

    // Unchecked power-up reset so the model and the DUT start from a known state.
    drive(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge Clk); #1;
    model_edge(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);

    // Reset beats load.
    step(1'b0, 1'b1, 2'b11, 8'h05, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0);
    check("t1_q", 32'(if0.Q), 32'h0);
    check("t1_qb", 32'(if0.Qb), 32'hF);

    // Load, then load with En low must hold.
    step(1'b0, 1'b1, 2'b11, 8'h0A, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'b11, 8'h05, 1'b0, 1'b0, 1'b0);
    check("t2_hold_q", 32'(if0.Q), 32'hA);

    // Four right shifts with SerInMsb=1: full pass and Wrap pulse.
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_serlsb%0d", k), 32'(if0.SerOutLsb), 32'(exp_sol[k]));
      step(1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0);
      check($sformatf("t3_q%0d", k), 32'(if0.Q), 32'(exp_q[k]));
      check($sformatf("t3_cnt%0d", k), 32'(if0.ShiftCnt), 32'(exp_cnt[k]));
      check($sformatf("t3_wrap%0d", k), 32'(if0.Wrap), 32'(exp_wr[k]));
    end
    step(1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("t3_wrap_drop", 32'(if0.Wrap), 32'h0);

    // Shift left then load clears the count.
    check("t4_sermsb", 32'(if0.SerOutMsb), 32'h1);
    step(1'b0, 1'b1, 2'b10, 8'h00, 1'b1, 1'b0, 1'b0);
    check("t4_q", 32'(if0.Q), 32'hE);
    step(1'b0, 1'b1, 2'b11, 8'h03, 1'b0, 1'b0, 1'b0);
    check("t4_load_q", 32'(if0.Q), 32'h3);
    check("t4_load_cnt", 32'(if0.ShiftCnt), 32'h0);

    // Reset in the middle of a shift sequence.
    step(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0);
    check("t5_cnt_before", 32'(if0.ShiftCnt), 32'h2);
    step(1'b1, 1'b1, 2'b01, 8'h00, 1'b1, 1'b1, 1'b0);
    check("t5_q0", 32'(if0.Q), 32'h0);
    check("t5_cnt0", 32'(if0.ShiftCnt), 32'h0);
    check("t5_q1", 32'(if1.Q), 32'h9);
    check("t5_qb1", 32'(if1.Qb), 32'h6);

    // Five shifts on the width-5 instance wrap on the 5th, not the 4th.
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, (k % 2 == 0) ? 2'b01 : 2'b10, 8'h00, 1'b1, 1'b0, 1'b0);
      check($sformatf("t5_w5wrap%0d", k), 32'(if2.Wrap), (k == 4) ? 32'h1 : 32'h0);
    end

`ifdef SHIFT_REG_ROTATE_EN
    step(1'b0, 1'b1, 2'b11, 8'h08, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b1, 1'b1);
    check("t6_ror", 32'(if0.Q), 32'h4);
    step(1'b0, 1'b1, 2'b10, 8'h00, 1'b1, 1'b1, 1'b1);
    check("t6_rol1", 32'(if0.Q), 32'h8);
    step(1'b0, 1'b1, 2'b10, 8'h00, 1'b1, 1'b1, 1'b1);
    check("t6_rol2", 32'(if0.Q), 32'h1);
`endif

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      step(($urandom % 32) == 0, ($urandom % 4) != 0, 2'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
